// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// default sizing and the FSM state encoding.
package sar_pkg;

    localparam int unsigned SAR_WIDTH   = 6;
    localparam int unsigned SAR_CMP_LAT = 1;

    // Settle counter must hold CMP_LAT values 0..15
    localparam int unsigned SAR_CNT_W   = 4;

    localparam int unsigned STATE_W     = 2;

    typedef logic [STATE_W-1:0] sar_state_t;

    localparam sar_state_t S_IDLE = 2'd0;
    localparam sar_state_t S_WAIT = 2'd1;
    localparam sar_state_t S_DONE = 2'd2;

endpackage : sar_pkg

// File: rtl/sar_settle_timer.sv
// Loadable down-counter that times the comparator settle interval; zero_c
// flags that the currently held trial has settled long enough to sample.
module sar_settle_timer
    import sar_pkg::*;
#(
    parameter int unsigned CNT_W = SAR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule : sar_settle_timer

// File: rtl/sar_search_ctrl.sv
// SAR controller: drives a trial operand into a magnitude comparator and
// resolves the unknown operand MSB-first from the gt/lt/eq flags.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH   = SAR_WIDTH,
    parameter int unsigned CMP_LAT = SAR_CMP_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_INIT   = BIT_W'(WIDTH - 1);
    localparam logic [SAR_CNT_W-1:0] LAT_VAL = SAR_CNT_W'(CMP_LAT);

    sar_state_t       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exact_q, exact_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             tmr_load;
    logic             settled_c;
    logic             flags_ok_c;
    logic             sample_c;
    logic             last_bit_c;
    logic [WIDTH-1:0] step_trial_c;

    sar_settle_timer #(
        .CNT_W (SAR_CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (LAT_VAL),
        .zero_c   (settled_c)
    );

    assign flags_ok_c = $onehot({cmp_gt, cmp_lt, cmp_eq});
    assign sample_c   = (state_q == S_WAIT) && settled_c;
    assign last_bit_c = (bit_q == '0);

    // Trial after a gt/lt decision: drop the current bit on gt, then probe the next one
    always_comb begin
        step_trial_c = trial_q;
        if (cmp_gt) begin
            step_trial_c = step_trial_c & ~(WIDTH'(1) << bit_q);
        end
        if (!last_bit_c) begin
            step_trial_c = step_trial_c | (WIDTH'(1) << (bit_q - BIT_W'(1)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sample_c && (!flags_ok_c || cmp_eq || last_bit_c)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = start ? S_WAIT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        trial_d  = trial_q;
        bit_d    = bit_q;
        result_d = result_q;
        exact_d  = exact_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d == S_WAIT);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    trial_d  = TRIAL_INIT;
                    bit_d    = BIT_INIT;
                    tmr_load = 1'b1;
                    result_d = '0;
                    exact_d  = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_WAIT: begin
                if (sample_c) begin
                    if (!flags_ok_c) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        exact_d  = 1'b0;
                    end else if (cmp_eq) begin
                        result_d = trial_q;
                        exact_d  = 1'b1;
                    end else begin
                        trial_d = step_trial_c;
                        if (last_bit_c) begin
                            result_d = step_trial_c;
                            exact_d  = 1'b0;
                        end else begin
                            bit_d    = bit_q - BIT_W'(1);
                            tmr_load = 1'b1;
                        end
                    end
                end
            end
            default: begin
                done_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trial_q  <= '0;
            bit_q    <= '0;
            result_q <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            trial_q  <= trial_d;
            bit_q    <= bit_d;
            result_q <= result_d;
            exact_q  <= exact_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign trial  = trial_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign exact  = exact_q;
    assign err    = err_q;

endmodule : sar_search_ctrl

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: a behavioural comparator answers
// each trial one cycle late, and a binary-search model predicts every run.
module tb_sar_search_ctrl;

    localparam int unsigned W   = 6;
    localparam int unsigned LAT = 1;
    localparam int          BUDGET = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cmp_gt, cmp_lt, cmp_eq;
    logic [W-1:0] trial;
    logic         busy, done;
    logic [W-1:0] result;
    logic         exact, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] b_val = '0;
    int           force_mode = 0;
    logic [W-1:0] trial_dly;

    int           got_cyc, got_busy_done, got_done_after;
    logic [W-1:0] got_res;
    logic         got_exact, got_err;
    logic [W-1:0] got_tr[$];

    logic [W-1:0] exp_tr[$];
    logic [W-1:0] exp_res;
    logic         exp_exact;
    int           exp_cyc;

    sar_search_ctrl #(.WIDTH(W), .CMP_LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .exact  (exact),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Comparator with one cycle of propagation delay from trial to flags
    always @(posedge clk or posedge rst) begin
        if (rst) trial_dly <= '0;
        else     trial_dly <= trial;
    end

    always_comb begin
        cmp_gt = (trial_dly > b_val);
        cmp_lt = (trial_dly < b_val);
        cmp_eq = (trial_dly == b_val);
        if (force_mode == 1) begin
            cmp_gt = 1'b1; cmp_lt = 1'b1; cmp_eq = 1'b0;
        end else if (force_mode == 2) begin
            cmp_gt = 1'b0; cmp_lt = 1'b0; cmp_eq = 1'b0;
        end
    end

    // Plain binary search over the bit weights: probe acc+2^i, keep it if not above B
    task automatic model(input logic [W-1:0] b);
        logic [W-1:0] acc, t;
        int steps;
        acc = '0; steps = 0; exp_exact = 1'b0;
        exp_tr.delete();
        for (int i = W - 1; i >= 0; i--) begin
            t = acc | W'(1 << i);
            exp_tr.push_back(t);
            steps++;
            if (t == b) begin
                acc = t; exp_exact = 1'b1;
                break;
            end
            if (t < b) acc = t;
        end
        exp_res = acc;
        exp_cyc = steps * int'(LAT + 1) + 1;
    endtask

    task automatic run_search(input logic [W-1:0] b, input int mode, input bit noisy);
        b_val = b; force_mode = mode;
        got_tr.delete();
        got_cyc = -1; got_res = 'x; got_exact = 1'bx; got_err = 1'bx; got_busy_done = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= BUDGET; c++) begin
            if (busy && (got_tr.size() == 0 || got_tr[$] != trial)) got_tr.push_back(trial);
            if (done) begin
                got_cyc = c; got_res = result; got_exact = exact; got_err = err;
                got_busy_done = int'(busy);
                break;
            end
            if (noisy) start = busy ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1 got_done_after = int'(done);
        force_mode = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({trial, busy, done, result, exact, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got trial=%0d busy=%b done=%b result=%0d exact=%b err=%b, want all 0",
                     trial, busy, done, result, exact, err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_search(input logic [W-1:0] b, input bit noisy);
        model(b);
        run_search(b, 0, noisy);
        n_checks++;
        if (got_cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL search_latency B=%0d: got %0d cycles, want %0d", b, got_cyc, exp_cyc);
        end
        n_checks++;
        if (got_res !== exp_res || got_exact !== exp_exact || got_err !== 1'b0) begin
            n_fail++;
            $display("FAIL search_result B=%0d: got result=%0d exact=%b err=%b, want %0d %b 0",
                     b, got_res, got_exact, got_err, exp_res, exp_exact);
        end
        n_checks++;
        if (got_tr.size() != exp_tr.size()) begin
            n_fail++;
            $display("FAIL trial_count B=%0d: got %0d trials, want %0d", b, got_tr.size(), exp_tr.size());
        end else begin
            for (int i = 0; i < exp_tr.size(); i++) begin
                n_checks++;
                if (got_tr[i] !== exp_tr[i]) begin
                    n_fail++;
                    $display("FAIL trial_seq B=%0d step %0d: got %0d, want %0d", b, i, got_tr[i], exp_tr[i]);
                end
            end
        end
        n_checks++;
        if (got_busy_done != 0 || got_done_after != 0) begin
            n_fail++;
            $display("FAIL done_pulse B=%0d: got busy_in_done=%0d done_next=%0d, want 0 0",
                     b, got_busy_done, got_done_after);
        end
    endtask

    task automatic test_illegal(input int mode);
        run_search(6'd45, mode, 1'b0);
        n_checks++;
        if (got_cyc != int'(LAT) + 2 || got_err !== 1'b1 || got_res !== '0 || got_exact !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_flags mode=%0d: got cyc=%0d err=%b result=%0d exact=%b, want %0d 1 0 0",
                     mode, got_cyc, got_err, got_res, got_exact, LAT + 2);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        b_val = 6'd45;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (trial == 6'd40) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL midreset_reach: got trial=%0d, third trial 40 never seen", trial);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({trial, busy, done, result, exact, err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got trial=%0d busy=%b done=%b result=%0d exact=%b err=%b, want all 0",
                     trial, busy, done, result, exact, err);
        end
        rst = 1'b0;
        test_search(6'($urandom_range(0, 63)), 1'b0);
    endtask

    task automatic test_back_to_back(input logic [W-1:0] b1, input logic [W-1:0] b2);
        int c1;
        c1 = -1;
        b_val = b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= BUDGET; c++) begin
            if (done) begin
                c1 = c;
                break;
            end
            @(posedge clk); #1;
        end
        model(b1);
        n_checks++;
        if (c1 != exp_cyc || result !== exp_res) begin
            n_fail++;
            $display("FAIL b2b_first: got cyc=%0d result=%0d, want %0d %0d", c1, result, exp_cyc, exp_res);
        end
        b_val = b2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || trial !== W'(1 << (W - 1)) || result !== '0 || exact !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b done=%b trial=%0d result=%0d exact=%b, want 1 0 32 0 0",
                     busy, done, trial, result, exact);
        end
        model(b2);
        c1 = -1;
        for (int c = 1; c <= BUDGET; c++) begin
            if (done) begin
                c1 = c;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (c1 != exp_cyc || result !== exp_res || exact !== exp_exact) begin
            n_fail++;
            $display("FAIL b2b_second B=%0d: got cyc=%0d result=%0d exact=%b, want %0d %0d %b",
                     b2, c1, result, exact, exp_cyc, exp_res, exp_exact);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy();
        for (int i = 0; i < 4; i++) test_search(6'($urandom_range(0, 63)), 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) test_search(6'($urandom_range(0, 63)), 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        test_reset();
        test_search(6'd32, 1'b0);
        test_search(6'd45, 1'b0);
        test_search(6'd0,  1'b0);
        test_search(6'd63, 1'b0);
        test_search(6'd1,  1'b0);
        test_illegal(1);
        test_illegal(2);
        test_reset_mid();
        test_start_busy();
        test_back_to_back(6'd45, 6'd0);
        test_back_to_back(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sar_search_ctrl
